// File: rtl/capture_pkg.sv
// Shared types and default sizing for the multi-channel input-capture block.
package capture_pkg;

  // Per-channel edge selection; bit 0 enables rising, bit 1 enables falling.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_FLT_WIDTH = 4;
  localparam int DEF_TS_WIDTH  = 16;

endpackage

// File: rtl/multi_capture_if.sv
// Per-channel bundle between the capture top level and one capture channel.
interface multi_capture_if
  import capture_pkg::*;
#(
  parameter int TS_WIDTH = DEF_TS_WIDTH
) ();

  logic                d;
  edge_mode_e          mode;
  logic                ack;
  logic                filtered;
  logic [TS_WIDTH-1:0] cap_ts;
  logic                cap_level;
  logic                cap_valid;
  logic                cap_ovf;

  // Top-level side: supplies pin, mode and acknowledge, reads capture state.
  modport master (
    output d, mode, ack,
    input  filtered, cap_ts, cap_level, cap_valid, cap_ovf
  );

  // Channel side.
  modport slave (
    input  d, mode, ack,
    output filtered, cap_ts, cap_level, cap_valid, cap_ovf
  );

endinterface

// File: rtl/capture_channel.sv
// One capture channel: glitch filter, edge detector and single-entry
// capture register with overflow flag.
module capture_channel
  import capture_pkg::*;
#(
  parameter int FLT_WIDTH = DEF_FLT_WIDTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena_i,
  input  logic [FLT_WIDTH-1:0] flt_val_i,
  input  logic [TS_WIDTH-1:0]  ts_now_i,
  multi_capture_if.slave       bus
);

  logic [FLT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 filt_q, filt_d;
  logic                 prev_q, prev_d;
  logic                 ena_dly_q;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic                 level_q, level_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 edge_ev;
  logic                 rise_en, fall_en;

  // Edge event: first enabled cycle showing a new filtered level, gated by
  // the mode; suppressed on the first cycle after ena returns so held
  // history cannot fire a stale edge.
  always_comb begin
    rise_en = (bus.mode == EDGE_RISE) || (bus.mode == EDGE_BOTH);
    fall_en = (bus.mode == EDGE_FALL) || (bus.mode == EDGE_BOTH);
    edge_ev = 1'b0;
    if (ena_i && ena_dly_q && (filt_q != prev_q)) begin
      edge_ev = filt_q ? rise_en : fall_en;
    end
  end

  // Glitch filter: count cycles of disagreement, adopt d once count reaches
  // flt_val; any agreement restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    prev_d = prev_q;
    if (ena_i) begin
      prev_d = filt_q;
      if (bus.d == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q < flt_val_i) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        filt_d = bus.d;
        cnt_d  = '0;
      end
    end
  end

  // Capture register: an ack in the event cycle frees the slot for the new
  // edge; otherwise a second edge only raises overflow and keeps the first.
  always_comb begin
    ts_d    = ts_q;
    level_d = level_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (edge_ev) begin
      if (!valid_q || bus.ack) begin
        ts_d    = ts_now_i;
        level_d = filt_q;
        valid_d = 1'b1;
        ovf_d   = 1'b0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ena_i && bus.ack) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      filt_q    <= 1'b0;
      prev_q    <= 1'b0;
      ena_dly_q <= 1'b0;
      ts_q      <= '0;
      level_q   <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      prev_q    <= prev_d;
      ena_dly_q <= ena_i;
      ts_q      <= ts_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.filtered  = filt_q;
  assign bus.cap_ts    = ts_q;
  assign bus.cap_level = level_q;
  assign bus.cap_valid = valid_q;
  assign bus.cap_ovf   = ovf_q;

endmodule

// File: rtl/multi_capture.sv
// Multi-channel input capture: shared free-running timestamp plus one
// independent filter/capture channel per input pin.
module multi_capture
  import capture_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int FLT_WIDTH = DEF_FLT_WIDTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [CHANNELS-1:0]          d,
  input  logic [FLT_WIDTH-1:0]         flt_val,
  input  logic [2*CHANNELS-1:0]        edge_mode,
  input  logic [CHANNELS-1:0]          cap_ack,
  output logic [CHANNELS-1:0]          filtered,
  output logic [TS_WIDTH*CHANNELS-1:0] cap_ts,
  output logic [CHANNELS-1:0]          cap_level,
  output logic [CHANNELS-1:0]          cap_valid,
  output logic [CHANNELS-1:0]          cap_ovf,
  output logic [TS_WIDTH-1:0]          ts_now
);

  logic [TS_WIDTH-1:0] ts_q, ts_d;

  // Timestamp advances on enabled cycles and wraps naturally.
  always_comb begin
    ts_d = ts_q;
    if (ena) ts_d = ts_q + 1'b1;
  end

  // Timestamp register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_d;
  end

  assign ts_now = ts_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_capture_if #(.TS_WIDTH(TS_WIDTH)) bus ();

    assign bus.d    = d[g];
    assign bus.mode = edge_mode_e'(edge_mode[2*g +: 2]);
    assign bus.ack  = cap_ack[g];

    assign filtered[g]                   = bus.filtered;
    assign cap_ts[TS_WIDTH*g +: TS_WIDTH] = bus.cap_ts;
    assign cap_level[g]                  = bus.cap_level;
    assign cap_valid[g]                  = bus.cap_valid;
    assign cap_ovf[g]                    = bus.cap_ovf;

    capture_channel #(
      .FLT_WIDTH(FLT_WIDTH),
      .TS_WIDTH (TS_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (ena),
      .flt_val_i(flt_val),
      .ts_now_i (ts_q),
      .bus      (bus.slave)
    );
  end

endmodule

// File: tb/tb_multi_capture.sv
// Directed bench for multi_capture with default sizing (4 ch, 4-bit filter,
// 16-bit timestamp).
module tb_multi_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  d;
  logic [3:0]  flt_val;
  logic [7:0]  edge_mode;
  logic [3:0]  cap_ack;
  logic [3:0]  filtered;
  logic [63:0] cap_ts;
  logic [3:0]  cap_level;
  logic [3:0]  cap_valid;
  logic [3:0]  cap_ovf;
  logic [15:0] ts_now;

  int tests = 0;
  int fails = 0;

  multi_capture #(.CHANNELS(4), .FLT_WIDTH(4), .TS_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .d        (d),
    .flt_val  (flt_val),
    .edge_mode(edge_mode),
    .cap_ack  (cap_ack),
    .filtered (filtered),
    .cap_ts   (cap_ts),
    .cap_level(cap_level),
    .cap_valid(cap_valid),
    .cap_ovf  (cap_ovf),
    .ts_now   (ts_now)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ts(input logic [15:0] v);
    int n;
    n = 0;
    while (ts_now !== v && n < 70000) begin
      tick();
      n++;
    end
    tests++;
    assert (ts_now === v) else begin
      fails++;
      $error("FAIL wait_ts: observed %0h expected %0h", ts_now, v);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timestamp never reached target");
    end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; d = 4'b0000; flt_val = 4'd0;
    edge_mode = 8'h00; cap_ack = 4'b0000;
    ticks(3);
    check("rst_filtered", filtered, 4'b0000);
    check("rst_valid",    cap_valid, 4'b0000);
    check("rst_ovf",      cap_ovf, 4'b0000);
    check("rst_level",    cap_level, 4'b0000);
    check("rst_cap_ts",   cap_ts, 64'h0);
    check("rst_ts_now",   ts_now, 16'h0000);

    rst = 1'b1; ena = 1'b1; edge_mode = 8'b00_00_00_01;
    ticks(5);
    check("ts_count5", ts_now, 16'h0005);

    // Rising capture at 0x0010
    wait_ts(16'h000F);
    d[0] = 1'b1;
    tick();
    check("ev_ts_now",   ts_now, 16'h0010);
    check("ev_filtered", filtered[0], 1'b1);
    check("ev_valid_lag", cap_valid[0], 1'b0);
    tick();
    check("cap10_ts",    cap_ts[15:0], 16'h0010);
    check("cap10_level", cap_level[0], 1'b1);
    check("cap10_valid", cap_valid[0], 1'b1);
    check("cap10_ovf",   cap_ovf[0], 1'b0);

    // Fall (not enabled) then second rise without ack -> overflow
    d[0] = 1'b0; tick();
    d[0] = 1'b1; tick(); tick();
    check("ovf_ts_kept", cap_ts[15:0], 16'h0010);
    check("ovf_level",   cap_level[0], 1'b1);
    check("ovf_flag",    cap_ovf[0], 1'b1);
    check("ovf_valid",   cap_valid[0], 1'b1);
    cap_ack[0] = 1'b1; tick(); cap_ack[0] = 1'b0;
    check("ack_valid", cap_valid[0], 1'b0);
    check("ack_ovf",   cap_ovf[0], 1'b0);
    cap_ack[0] = 1'b1; tick(); cap_ack[0] = 1'b0;
    check("ack_idle_valid", cap_valid[0], 1'b0);
    check("ack_idle_ovf",   cap_ovf[0], 1'b0);

    // Ack colliding with a new event at 0x0042
    d[0] = 1'b0; tick();
    d[0] = 1'b1; tick(); tick();
    check("pre_coll_valid", cap_valid[0], 1'b1);
    d[0] = 1'b0; tick();
    wait_ts(16'h0041);
    d[0] = 1'b1; tick();
    cap_ack[0] = 1'b1; tick(); cap_ack[0] = 1'b0;
    check("coll_ts",    cap_ts[15:0], 16'h0042);
    check("coll_valid", cap_valid[0], 1'b1);
    check("coll_ovf",   cap_ovf[0], 1'b0);
    cap_ack[0] = 1'b1; tick(); cap_ack[0] = 1'b0;

    // Filter on channel 1 (mode off): flt_val=3
    flt_val = 4'd3;
    d[1] = 1'b1;
    ticks(3);
    check("flt_wait3", filtered[1], 1'b0);
    tick();
    check("flt_rise4", filtered[1], 1'b1);
    tick();
    check("flt_mode_off", cap_valid[1], 1'b0);
    d[1] = 1'b0; ticks(3);
    d[1] = 1'b1; ticks(2);
    check("flt_pulse3", filtered[1], 1'b1);
    flt_val = 4'd0;

    // Mode both on channel 2
    edge_mode = 8'b00_11_00_01;
    wait_ts(16'h005F);
    d[2] = 1'b1; tick(); tick();
    check("both_rise_ts",  cap_ts[47:32], 16'h0060);
    check("both_rise_lvl", cap_level[2], 1'b1);
    check("both_rise_vld", cap_valid[2], 1'b1);
    cap_ack[2] = 1'b1; tick(); cap_ack[2] = 1'b0;
    wait_ts(16'h006F);
    d[2] = 1'b0; tick(); tick();
    check("both_fall_ts",  cap_ts[47:32], 16'h0070);
    check("both_fall_lvl", cap_level[2], 1'b0);
    check("both_fall_vld", cap_valid[2], 1'b1);
    d[1] = 1'b0; tick(); tick();
    check("off_filtered", filtered[1], 1'b0);
    check("off_valid",    cap_valid[1], 1'b0);

    // Simultaneous edges on channels 0 and 3
    edge_mode = 8'b01_11_00_01;
    d[0] = 1'b0; tick();
    wait_ts(16'h008F);
    d[0] = 1'b1; d[3] = 1'b1; tick(); tick();
    check("sim_ts0",   cap_ts[15:0], 16'h0090);
    check("sim_ts3",   cap_ts[63:48], 16'h0090);
    check("sim_valid", cap_valid, 4'b1101);
    cap_ack = 4'b1001; tick(); cap_ack = 4'b0000;
    check("sim_ack", cap_valid, 4'b0100);

    // Enable low for 10 cycles freezes everything
    wait_ts(16'h00A0);
    ena = 1'b0; d = 4'b0110; cap_ack = 4'b0100;
    ticks(10);
    check("frz_ts",       ts_now, 16'h00A0);
    check("frz_filtered", filtered, 4'b1001);
    check("frz_valid",    cap_valid, 4'b0100);
    check("frz_cap_ts2",  cap_ts[47:32], 16'h0070);
    d = 4'b1001; cap_ack = 4'b0000; ena = 1'b1;
    ticks(2);
    check("resume_valid", cap_valid, 4'b0100);
    check("resume_ovf",   cap_ovf, 4'b0000);
    check("resume_filt",  filtered, 4'b1001);
    check("resume_ts",    ts_now, 16'h00A2);

    // Timestamp wrap with capture at 0xFFFF
    d[0] = 1'b0; tick();
    wait_ts(16'hFFFE);
    d[0] = 1'b1; tick(); tick();
    check("wrap_ts_now", ts_now, 16'h0000);
    check("wrap_cap_ts", cap_ts[15:0], 16'hFFFF);
    check("wrap_valid",  cap_valid[0], 1'b1);

    // Reset mid-filter
    flt_val = 4'd3; d[1] = 1'b1;
    ticks(2);
    rst = 1'b0;
    #1;
    check("mrst_ts",       ts_now, 16'h0000);
    check("mrst_filtered", filtered, 4'b0000);
    check("mrst_valid",    cap_valid, 4'b0000);
    check("mrst_ovf",      cap_ovf, 4'b0000);
    check("mrst_level",    cap_level, 4'b0000);
    check("mrst_cap_ts",   cap_ts, 64'h0);
    d = 4'b0010;
    tick();
    rst = 1'b1;
    tick();
    check("rel_no_edge", cap_valid, 4'b0000);
    ticks(2);
    check("rel_cnt_discarded", filtered[1], 1'b0);
    tick();
    check("rel_filter_fresh", filtered, 4'b0010);
    check("rel_valid", cap_valid, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
